// File: rtl/input_conditioner_pkg.sv
// Shared encodings and default parameters for the switch/button input conditioner.
// State bit 1 doubles as the debounced level so no output decode is needed.
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      CHECK_HIGH = 2'b01,
      HIGH       = 2'b11,
      CHECK_LOW  = 2'b10
   } db_state_t;

   localparam int DEBOUNCE_MAX_DEFAULT = 1_000_000;
   localparam int CNT_WIDTH_DEFAULT    = 20;
   localparam int DEBOUNCE_MAX_SIM     = 4;

endpackage

// File: rtl/debounce_fsm.sv
// Two-flop synchroniser followed by a counter-qualified debounce state machine.
// A change is accepted only after DEBOUNCE_MAX further stable cycles.
module debounce_fsm
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEFAULT,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic checking
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_MAX - 1);

   logic [1:0]           sync_reg;
   db_state_t            state_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 rise_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg  <= 2'b00;
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rise_reg  <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], din};
         rise_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sync_reg[1]) begin
                  state_reg <= CHECK_HIGH;
                  cnt_reg   <= '0;
               end
            end
            CHECK_HIGH: begin
               if (!sync_reg[1]) begin
                  state_reg <= IDLE;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= HIGH;
                  rise_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            HIGH: begin
               if (!sync_reg[1]) begin
                  state_reg <= CHECK_LOW;
                  cnt_reg   <= '0;
               end
            end
            CHECK_LOW: begin
               // A return to 1 mid-qualification is a bounce: back to HIGH, no new pulse.
               if (sync_reg[1]) begin
                  state_reg <= HIGH;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign level    = state_reg[1];
   assign checking = state_reg[1] ^ state_reg[0];
   assign rise     = rise_reg;

endmodule

// File: rtl/input_conditioner.sv
// Front end for the sequence detector: debounced switch level, step strobe,
// qualification-busy flag and a wrapping count of accepted presses.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEFAULT,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_step,
   input  logic       sw_w,
   output logic       w,
   output logic       step,
   output logic       busy,
   output logic [7:0] press_count
);

   logic       step_rise;
   logic [7:0] press_count_reg;

   debounce_fsm #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_sw (
      .clk      (clk),
      .reset    (reset),
      .din      (sw_w),
      .level    (w),
      .rise     (),
      .checking ()
   );

   debounce_fsm #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_btn (
      .clk      (clk),
      .reset    (reset),
      .din      (btn_step),
      .level    (),
      .rise     (step_rise),
      .checking (busy)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         press_count_reg <= 8'd0;
      end else if (step_rise) begin
         press_count_reg <= press_count_reg + 8'd1;
      end
   end

   assign step        = step_rise;
   assign press_count = press_count_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_MAX=4: directed timing
// scenarios plus randomized stimulus against a run-length reference model.
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int DM  = DEBOUNCE_MAX_SIM;
   localparam int LAT = DM + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_step = 1'b0;
   logic       sw_w = 1'b0;
   logic       w, step, busy;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;

   input_conditioner #(
      .DEBOUNCE_MAX (DM),
      .CNT_WIDTH    (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_step    (btn_step),
      .sw_w        (sw_w),
      .w           (w),
      .step        (step),
      .busy        (busy),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   // Reference model: the qualifier sees each raw input two edges late; the accepted
   // level flips once the seen value has disagreed with it for DM+1 consecutive edges.
   logic [1:0] dly_b, dly_w;
   logic       lvl_b, lvl_w, m_step;
   int         run_b, run_w;
   logic [7:0] m_count;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dly_b <= 2'b00; dly_w <= 2'b00;
         lvl_b <= 1'b0;  lvl_w <= 1'b0;
         run_b <= 0;     run_w <= 0;
         m_step <= 1'b0; m_count <= 8'd0;
      end else begin
         dly_b  <= {dly_b[0], btn_step};
         dly_w  <= {dly_w[0], sw_w};
         m_step <= 1'b0;
         if (m_step) m_count <= m_count + 8'd1;
         if (dly_b[1] != lvl_b) begin
            if (run_b == DM) begin
               lvl_b <= ~lvl_b; run_b <= 0; m_step <= ~lvl_b;
            end else run_b <= run_b + 1;
         end else run_b <= 0;
         if (dly_w[1] != lvl_w) begin
            if (run_w == DM) begin
               lvl_w <= ~lvl_w; run_w <= 0;
            end else run_w <= run_w + 1;
         end else run_w <= 0;
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         btn_step = 1'($urandom);
         sw_w     = 1'($urandom);
         checks++;
         if ({w, step, busy, press_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: w=%b step=%b busy=%b count=%0d, expected all 0", k, w, step, busy, press_count);
         end
      end
      @(negedge clk);
      btn_step = 1'b0; sw_w = 1'b0; reset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if ({w, step, busy, press_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release cycle %0d: w=%b step=%b busy=%b count=%0d, expected all 0", k, w, step, busy, press_count);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_clean_press();
      btn_step = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'(k == LAT)) begin
            errors++; $display("FAIL press_step k=%0d: got %b expected %b", k, step, k == LAT);
         end
         checks++;
         if (busy !== 1'(k >= 2 && k < LAT)) begin
            errors++; $display("FAIL press_busy k=%0d: got %b expected %b", k, busy, k >= 2 && k < LAT);
         end
         checks++;
         if (press_count !== ((k > LAT) ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL press_count k=%0d: got %0d expected %0d", k, press_count, (k > LAT) ? 1 : 0);
         end
      end
      btn_step = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'b0 || press_count !== 8'd1) begin
            errors++; $display("FAIL release_step k=%0d: step=%b count=%0d expected 0 and 1", k, step, press_count);
         end
         checks++;
         if (busy !== 1'(k >= 2 && k < LAT)) begin
            errors++; $display("FAIL release_busy k=%0d: got %b expected %b", k, busy, k >= 2 && k < LAT);
         end
      end
      $display("test_clean_press done");
   endtask

   task automatic test_bounce();
      int pulses = 0;
      btn_step = 1'b1;
      @(negedge clk);
      @(negedge clk); btn_step = 1'b0;
      @(negedge clk); btn_step = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (step === 1'b1) pulses++;
         checks++;
         if (step !== 1'(k == LAT)) begin
            errors++; $display("FAIL bounce_step k=%0d: got %b expected %b", k, step, k == LAT);
         end
      end
      checks++;
      if (pulses != 1 || press_count !== 8'd2) begin
         errors++; $display("FAIL bounce_total: pulses=%0d count=%0d expected 1 and 2", pulses, press_count);
      end
      btn_step = 1'b0;
      repeat (12) @(negedge clk);
      $display("test_bounce done");
   endtask

   task automatic test_switch();
      sw_w = 1'b1;
      repeat (3) @(negedge clk);
      sw_w = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++;
         if (w !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL switch_glitch k=%0d: w=%b busy=%b expected 0 0", k, w, busy);
         end
      end
      sw_w = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++;
         if (w !== 1'(k >= LAT)) begin
            errors++; $display("FAIL switch_rise k=%0d: got %b expected %b", k, w, k >= LAT);
         end
      end
      sw_w = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++;
         if (w !== 1'(k < LAT)) begin
            errors++; $display("FAIL switch_fall k=%0d: got %b expected %b", k, w, k < LAT);
         end
      end
      $display("test_switch done");
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 257; i++) begin
         btn_step = 1'b1;
         repeat (8) @(negedge clk);
         btn_step = 1'b0;
         repeat (8) @(negedge clk);
         checks++;
         if (press_count !== 8'(i + 1)) begin
            errors++; $display("FAIL wrap_count press %0d: got %0d expected %0d", i + 1, press_count, 8'(i + 1));
         end
      end
      $display("test_wrap done count=%0d", press_count);
   endtask

   task automatic test_reset_mid();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      btn_step = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL mid_busy: got %b expected 1", busy);
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'b0 || busy !== 1'b0 || press_count !== 8'd0) begin
            errors++; $display("FAIL mid_in_reset k=%0d: step=%b busy=%b count=%0d expected 0 0 0", k, step, busy, press_count);
         end
      end
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (step !== 1'(k == LAT) || press_count !== ((k > LAT) ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL mid_requalify k=%0d: step=%b count=%0d expected %b %0d", k, step, press_count, k == LAT, (k > LAT) ? 1 : 0);
         end
      end
      btn_step = 1'b0;
      repeat (12) @(negedge clk);
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int   cyc = 0;
      int   hold;
      logic prev_step = 1'b0;
      while (cyc < 3000) begin
         btn_step = 1'($urandom);
         sw_w     = 1'($urandom);
         hold     = int'($urandom_range(1, 2 * DM + 3));
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (w !== lvl_w || step !== m_step || busy !== (run_b != 0) || press_count !== m_count) begin
               errors++;
               $display("FAIL random cycle %0d: w=%b step=%b busy=%b count=%0d expected %b %b %b %0d",
                        cyc, w, step, busy, press_count, lvl_w, m_step, run_b != 0, m_count);
            end
            checks++;
            if (prev_step === 1'b1 && step === 1'b1) begin
               errors++; $display("FAIL random_step_twice cycle %0d: step high on two consecutive cycles", cyc);
            end
            prev_step = step;
         end
      end
      $display("test_random done cycles=%0d presses=%0d", cyc, m_count);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_switch();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
